zigbee_pad_mux: RTL and testbench
=================================

Name: zigbee_pad_mux

Overview:
- Parametrised pad-side channel multiplexer between the pad ring and the platform core.
- Generalises the fixed 2-bit-select / 22-in / 18-out pad interface to N_CH channels of configurable width.
- Adds three behaviours:
  - Synchronisation of all pad inputs.
  - Strobe-qualified capture of input words into per-channel registers.
  - Glitch-free, blanked switching of the output pins when the select changes.

Parameters:
- IN_W, 22, width of input pad bus
- OUT_W, 18, width of output pad bus
- N_CH, 4, number of channels (>=2)
- SEL_W, $clog2(N_CH), select width
- SYNC_STAGES, 2, synchroniser depth for all pad inputs (>=2)
- BLANK_CYC, 4, output-blanking cycles after a select change (>=1)

Ports:
- clk_i  in  1  core clock
- resetn_i  in  1  asynchronous active-low reset
- sel_i  in  SEL_W  channel select from pads, asynchronous
- strobe_i  in  1  capture strobe from pad, asynchronous
- pad_in_i  in  IN_W  input data from pads, asynchronous
- pad_out_o  out  OUT_W  registered data to output pads
- ch_in_o  out  N_CH*IN_W  per-channel captured input words; channel k is bits [k*IN_W +: IN_W]
- ch_in_vld_o  out  N_CH  one-cycle pulse when channel k's word is updated
- ch_out_i  in  N_CH*OUT_W  per-channel output words from the core
- busy_o  out  1  high while in BLANK
- drop_o  out  1  one-cycle pulse when a strobe edge is discarded

Behaviour:
- Clock and reset: one clock, clk_i. Reset resetn_i is asynchronous, active-low.
- Reset values:
  - All synchroniser flops, ch_in_o, ch_in_vld_o, pad_out_o, busy_o and drop_o are 0.
  - Committed select sel_q = 0; blank counter = 0; FSM = ACTIVE.
- Synchronisers:
  - sel_i, strobe_i and pad_in_i each pass through SYNC_STAGES flops, producing sel_s, stb_s and din_s, which are mutually aligned.
  - stb_d is stb_s delayed 1 cycle.
  - Strobe edge: stb_e = stb_s & ~stb_d.
- FSM states ACTIVE and BLANK:
  - ACTIVE, sel_s != sel_q: sel_q <= sel_s, counter <= BLANK_CYC-1, go to BLANK.
  - BLANK, sel_s != sel_q: sel_q <= sel_s, counter reloads to BLANK_CYC-1, stay in BLANK (restart).
  - BLANK, counter == 0 and no select change: go to ACTIVE.
  - BLANK, otherwise: counter decrements.
  - busy_o = (state == BLANK), registered.
- Output path:
  - pad_out_o <= (next state is BLANK) ? 0 : ch_out_i[sel_q_next].
  - Latency is one cycle from ch_out_i to pad_out_o.
  - pad_out_o never shows a mix of two channels; at least BLANK_CYC zero cycles separate two channels.
- Input capture:
  - If stb_e and the FSM stays in ACTIVE this cycle (no select change): ch_in_o[sel_q] <= din_s and ch_in_vld_o[sel_q] <= 1 for one cycle. All other channels hold.
  - If stb_e while in BLANK, or in the same cycle a select change is detected: no capture, drop_o pulses one cycle.
- Latency: strobe_i rising edge to ch_in_o update and vld pulse = SYNC_STAGES+1 cycles.
- Pad setup rule: pad_in_i must be stable from SYNC_STAGES+1 cycles before strobe_i rises until SYNC_STAGES+1 cycles after. Violations are not detected.
- Strobe held high produces exactly one capture. A new capture needs strobe_i low for at least 1 synchronised cycle.
- Out-of-range select (sel_s >= N_CH when N_CH is not a power of 2):
  - Treated as a valid select value, so it still triggers BLANK.
  - pad_out_o = 0 while selected.
  - Strobe edges are dropped, with a drop_o pulse.
- Reset asserted mid-BLANK or mid-capture: all state clears immediately. Outputs are 0 asynchronously and resume on the first clock after deassertion.

Test Plan:
- Reset, then ch_out_i[0]=18'h2A5A5 with sel_i=0 held: pad_out_o=18'h2A5A5 from the 1st cycle after reset release; busy_o=0.
- sel_i 0->2 with ch_out_i[2]=18'h11111: after SYNC_STAGES cycles, busy_o=1 and pad_out_o=0 for exactly 4 cycles, then pad_out_o=18'h11111.
- sel_i=1 stable, pad_in_i=22'h3ABCDE, strobe_i rising edge at cycle t: at t+3, ch_in_o channel 1=22'h3ABCDE and ch_in_vld_o=4'b0010 for one cycle; other channels unchanged.
- strobe_i held high for 10 cycles: exactly one vld pulse; toggling strobe low 1 cycle then high gives a second capture.
- sel_i changed 0->3, then 3->1 two cycles into BLANK: counter restarts, pad_out_o=0 for 2+4 cycles total, then shows ch_out_i[1].
- strobe edge during BLANK: drop_o pulses once, all ch_in_vld_o=0, ch_in_o unchanged; resetn_i pulsed mid-BLANK: pad_out_o=0 and busy_o=0 immediately, FSM returns to ACTIVE on channel 0.

Source files
------------

// File: rtl/zigbee_pad_mux.sv
// rtl/zigbee_pad_mux.sv - pad-side channel mux with synchronised inputs, strobed capture and blanked output switching
module zigbee_pad_mux #(
    parameter int IN_W        = 22,
    parameter int OUT_W       = 18,
    parameter int N_CH        = 4,
    parameter int SEL_W       = $clog2(N_CH),
    parameter int SYNC_STAGES = 2,
    parameter int BLANK_CYC   = 4
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    strobe_i,
    input  logic [IN_W-1:0]         pad_in_i,
    output logic [OUT_W-1:0]        pad_out_o,
    output logic [N_CH*IN_W-1:0]    ch_in_o,
    output logic [N_CH-1:0]         ch_in_vld_o,
    input  logic [N_CH*OUT_W-1:0]   ch_out_i,
    output logic                    busy_o,
    output logic                    drop_o
);

    localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLANK_CYC - 1);

    typedef enum logic {
        ACTIVE = 1'b0,
        BLANK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][SEL_W-1:0] sel_sync;
    logic [SYNC_STAGES-1:0]            stb_sync;
    logic [SYNC_STAGES-1:0][IN_W-1:0]  din_sync;
    logic                              stb_d;

    logic [SEL_W-1:0] sel_s;
    logic             stb_s;
    logic [IN_W-1:0]  din_s;
    logic             stb_e;

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_q, sel_q_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sel_chg;

    logic [OUT_W-1:0] out_word;
    logic [N_CH-1:0]  sel_oh;
    logic             capture_ok;

    // All pad inputs share one chain depth so sel_s, stb_s and din_s stay aligned.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sel_sync <= '0;
            stb_sync <= '0;
            din_sync <= '0;
            stb_d    <= 1'b0;
        end else begin
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], sel_i};
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], strobe_i};
            din_sync <= {din_sync[SYNC_STAGES-2:0], pad_in_i};
            stb_d    <= stb_sync[SYNC_STAGES-1];
        end
    end

    assign sel_s   = sel_sync[SYNC_STAGES-1];
    assign stb_s   = stb_sync[SYNC_STAGES-1];
    assign din_s   = din_sync[SYNC_STAGES-1];
    assign stb_e   = stb_s & ~stb_d;
    assign sel_chg = (sel_s != sel_q);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= ACTIVE;
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sel_q <= sel_q_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_q_n = sel_q;
        cnt_n   = cnt;
        case (state)
            ACTIVE: begin
                if (sel_chg) begin
                    sel_q_n = sel_s;
                    cnt_n   = CNT_RELOAD;
                    state_n = BLANK;
                end
            end
            BLANK: begin
                if (sel_chg) begin
                    sel_q_n = sel_s;
                    cnt_n   = CNT_RELOAD;
                end else if (cnt == '0) begin
                    state_n = ACTIVE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = ACTIVE;
        endcase
    end

    // Out-of-range selects match no channel, so they yield zero output and no capture target.
    always_comb begin
        out_word = '0;
        sel_oh   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_q_n == SEL_W'(k)) out_word = ch_out_i[k*OUT_W +: OUT_W];
            if (sel_q == SEL_W'(k))   sel_oh[k] = 1'b1;
        end
    end

    assign capture_ok = stb_e && (state == ACTIVE) && !sel_chg && (sel_oh != '0);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pad_out_o   <= '0;
            busy_o      <= 1'b0;
            drop_o      <= 1'b0;
            ch_in_o     <= '0;
            ch_in_vld_o <= '0;
        end else begin
            pad_out_o   <= (state_n == BLANK) ? '0 : out_word;
            busy_o      <= (state_n == BLANK);
            drop_o      <= stb_e & ~capture_ok;
            ch_in_vld_o <= '0;
            for (int k = 0; k < N_CH; k++) begin
                if (capture_ok && sel_oh[k]) begin
                    ch_in_o[k*IN_W +: IN_W] <= din_s;
                    ch_in_vld_o[k]          <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zigbee_pad_mux.sv
// tb/tb_zigbee_pad_mux.sv - self-checking bench for zigbee_pad_mux
module tb_zigbee_pad_mux;

    localparam int IN_W  = 22;
    localparam int OUT_W = 18;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    localparam logic [OUT_W-1:0] W0 = 18'h2A5A5;
    localparam logic [OUT_W-1:0] W1 = 18'h0F0F0;
    localparam logic [OUT_W-1:0] W2 = 18'h11111;
    localparam logic [OUT_W-1:0] W3 = 18'h22222;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [SEL_W-1:0]      sel;
    logic                  strobe;
    logic [IN_W-1:0]       pad_in;
    logic [OUT_W-1:0]      pad_out;
    logic [N_CH*IN_W-1:0]  ch_in;
    logic [N_CH-1:0]       ch_in_vld;
    logic [N_CH*OUT_W-1:0] ch_out;
    logic                  busy;
    logic                  drop;

    typedef struct {
        int              ch;
        logic [IN_W-1:0] data;
    } cap_t;

    cap_t            sb[$];
    logic [IN_W-1:0] exp_ch [N_CH];
    int              n_cmp = 0;
    int              n_bad = 0;

    zigbee_pad_mux #(
        .IN_W(IN_W), .OUT_W(OUT_W), .N_CH(N_CH), .SEL_W(SEL_W),
        .SYNC_STAGES(2), .BLANK_CYC(4)
    ) dut (
        .clk_i(clk), .resetn_i(resetn), .sel_i(sel), .strobe_i(strobe),
        .pad_in_i(pad_in), .pad_out_o(pad_out), .ch_in_o(ch_in),
        .ch_in_vld_o(ch_in_vld), .ch_out_i(ch_out), .busy_o(busy), .drop_o(drop)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; sel = '0; strobe = 1'b0; pad_in = '0;
        ch_out = {W3, W2, W1, W0};
        for (int k = 0; k < N_CH; k++) exp_ch[k] = '0;
        step(2);
        n_cmp++; if (pad_out !== '0) begin n_bad++; $display("FAIL reset_pad got %h want 0", pad_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (ch_in_vld !== '0 || drop !== 1'b0) begin n_bad++; $display("FAIL reset_pulses vld %b drop %b want 0", ch_in_vld, drop); end
        n_cmp++; if (ch_in !== '0) begin n_bad++; $display("FAIL reset_ch_in got %h want 0", ch_in); end
        resetn = 1'b1;
        step(1);
        n_cmp++; if (pad_out !== W0) begin n_bad++; $display("FAIL first_pad got %h want %h", pad_out, W0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL first_busy got %b want 0", busy); end
    endtask

    task automatic test_select_blank();
        sel = 2'd2;
        step(2);
        n_cmp++; if (pad_out !== W0 || busy !== 1'b0) begin n_bad++; $display("FAIL pre_blank pad %h busy %b want %h 0", pad_out, busy, W0); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_cmp++; if (pad_out !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL blank_%0d pad %h busy %b want 0 1", i, pad_out, busy); end
        end
        step(1);
        n_cmp++; if (pad_out !== W2 || busy !== 1'b0) begin n_bad++; $display("FAIL post_blank pad %h busy %b want %h 0", pad_out, busy, W2); end
    endtask

    task automatic test_capture();
        cap_t e;
        int   pulses;
        int   w;
        sel = 2'd1;
        step(8);
        pad_in = 22'h3ABCDE;
        step(3);
        strobe = 1'b1;
        sb.push_back('{1, 22'h3ABCDE});
        step(2);
        n_cmp++; if (ch_in_vld !== '0) begin n_bad++; $display("FAIL cap_early vld %b want 0", ch_in_vld); end
        step(1);
        n_cmp++; if (ch_in_vld !== 4'b0010) begin n_bad++; $display("FAIL cap_vld got %b want 0010", ch_in_vld); end
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL cap_sb empty queue got 0 want 1 entry"); end
        else begin
            e = sb.pop_front();
            exp_ch[e.ch] = e.data;
        end
        for (int k = 0; k < N_CH; k++) begin
            n_cmp++; if (ch_in[k*IN_W +: IN_W] !== exp_ch[k]) begin n_bad++; $display("FAIL cap_word_ch%0d got %h want %h", k, ch_in[k*IN_W +: IN_W], exp_ch[k]); end
        end
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (ch_in_vld !== '0) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL held_strobe extra pulses %0d want 0", pulses); end
        strobe = 1'b0;
        pad_in = 22'h155AA;
        step(1);
        strobe = 1'b1;
        sb.push_back('{1, 22'h155AA});
        w = 0;
        do begin step(1); w++; end while (ch_in_vld === '0 && w < 10);
        n_cmp++; if (ch_in_vld !== 4'b0010 || w != 3) begin n_bad++; $display("FAIL recap_vld got %b after %0d want 0010 after 3", ch_in_vld, w); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            exp_ch[e.ch] = e.data;
        end
        n_cmp++; if (ch_in[1*IN_W +: IN_W] !== exp_ch[1]) begin n_bad++; $display("FAIL recap_word got %h want %h", ch_in[1*IN_W +: IN_W], exp_ch[1]); end
        strobe = 1'b0;
        step(3);
    endtask

    task automatic test_restart();
        int  zc;
        int  w;
        bit  leak;
        sel = 2'd3;
        step(2);
        sel = 2'd1;
        zc = 0; w = 0; leak = 0;
        do begin
            step(1); w++;
            if (busy === 1'b1 && pad_out === '0) zc++;
            else if (busy === 1'b1 || pad_out === W3) leak = 1;
        end while (!(busy === 1'b0 && zc > 0) && w < 30);
        n_cmp++; if (zc != 6) begin n_bad++; $display("FAIL restart_blank got %0d zero cycles want 6", zc); end
        n_cmp++; if (leak) begin n_bad++; $display("FAIL restart_leak got 1 want 0"); end
        n_cmp++; if (pad_out !== W1) begin n_bad++; $display("FAIL restart_pad got %h want %h", pad_out, W1); end
    endtask

    task automatic test_drop_and_reset();
        sel = 2'd2;
        step(3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy got %b want 1", busy); end
        pad_in = 22'h2DEAD;
        strobe = 1'b1;
        step(3);
        n_cmp++; if (drop !== 1'b1 || ch_in_vld !== '0) begin n_bad++; $display("FAIL drop_pulse drop %b vld %b want 1 0", drop, ch_in_vld); end
        step(1);
        n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL drop_once got %b want 0", drop); end
        step(4);
        for (int k = 0; k < N_CH; k++) begin
            n_cmp++; if (ch_in[k*IN_W +: IN_W] !== exp_ch[k]) begin n_bad++; $display("FAIL drop_hold_ch%0d got %h want %h", k, ch_in[k*IN_W +: IN_W], exp_ch[k]); end
        end
        n_cmp++; if (pad_out !== W2) begin n_bad++; $display("FAIL drop_resume got %h want %h", pad_out, W2); end
        strobe = 1'b0;
        sel = 2'd3;
        step(3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy_pre got %b want 1", busy); end
        #2 resetn = 1'b0;
        sel = 2'd0;
        for (int k = 0; k < N_CH; k++) exp_ch[k] = '0;
        #1;
        n_cmp++; if (pad_out !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_async pad %h busy %b want 0 0", pad_out, busy); end
        n_cmp++; if (ch_in !== '0 || ch_in_vld !== '0) begin n_bad++; $display("FAIL rst_async_ch got %h want 0", ch_in); end
        @(negedge clk);
        resetn = 1'b1;
        step(1);
        n_cmp++; if (pad_out !== W0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_resume pad %h busy %b want %h 0", pad_out, busy, W0); end
        step(5);
        n_cmp++; if (busy !== 1'b0 || pad_out !== W0) begin n_bad++; $display("FAIL rst_stable pad %h busy %b want %h 0", pad_out, busy, W0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_select_blank();
        test_capture();
        test_restart();
        test_drop_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
